uart_cmd_sequencer: RTL

- Command front-end for the correlator control link.
- Consumes bytes from the UART receiver, parses short command frames, and maintains a bank of 8-bit configuration registers that drive the correlator.
- Issues one-cycle action strobes.
- Returns register read-backs through a transmitter handshake.
- Sole owner of the register bank; the host reaches the bank only through this block.

---
 rtl/uart_cmd_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_sequencer.sv
// UART command front-end: parses short byte frames into register writes, reads and action strobes.
// Optional trailing XOR checksum byte per frame when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int TIMEOUT  = 100000,
  parameter int TO_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [8*NUM_REGS-1:0] regs,
  output logic [15:0]           strobe,
  output logic                  busy,
  output logic                  err,
  output logic [7:0]            err_count
);

  localparam logic [3:0] OP_WR = 4'h1;
  localparam logic [3:0] OP_RD = 4'h2;
  localparam logic [3:0] OP_ST = 4'h3;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_EXEC, S_TX_REQ, S_TX_WAIT
`ifdef UART_CMD_CHECKSUM_EN
    , S_WAIT_CSUM
`endif
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t S_PAYLOAD_DONE = S_WAIT_CSUM;
  logic [7:0] csum;
`else
  localparam state_t S_PAYLOAD_DONE = S_EXEC;
`endif

  state_t                   state, state_nx;
  frame_t                   frm;
  logic                     rx_prev;
  logic                     byte_ev;
  logic [TO_WIDTH-1:0]      to_cnt;
  logic                     to_hit;
  logic                     seen_busy;
  logic [NUM_REGS-1:0][7:0] bank;
  logic                     addr_ok;
  logic [7:0]               rd_byte;
  logic                     op_ok;
  logic                     err_now;

  assign byte_ev = rx_done & ~rx_prev;
  assign to_hit  = (TIMEOUT != 0) && (to_cnt == TO_LAST);
  assign op_ok   = (rx_data[7:4] == OP_WR) || (rx_data[7:4] == OP_RD) || (rx_data[7:4] == OP_ST);
  assign regs    = bank;

  // Address decode by search keeps index widths exact for any NUM_REGS up to 16.
  always_comb begin
    addr_ok = 1'b0;
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (frm.addr == 4'(i)) begin
        addr_ok = 1'b1;
        rd_byte = bank[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_now  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (byte_ev) begin
          if (!op_ok)                    err_now  = 1'b1;
          else if (rx_data[7:4] == OP_WR) state_nx = S_WAIT_DATA;
          else                           state_nx = S_PAYLOAD_DONE;
        end
      end
      S_WAIT_DATA: begin
        if (byte_ev)     state_nx = S_PAYLOAD_DONE;
        else if (to_hit) begin
          err_now  = 1'b1;
          state_nx = S_IDLE;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_WAIT_CSUM: begin
        if (byte_ev) begin
          if (rx_data == csum) state_nx = S_EXEC;
          else begin
            err_now  = 1'b1;
            state_nx = S_IDLE;
          end
        end else if (to_hit) begin
          err_now  = 1'b1;
          state_nx = S_IDLE;
        end
      end
`endif
      S_EXEC: begin
        state_nx = S_IDLE;
        if (frm.op != OP_ST && !addr_ok) err_now  = 1'b1;
        else if (frm.op == OP_RD)        state_nx = S_TX_REQ;
        if (byte_ev)                     err_now  = 1'b1;
      end
      S_TX_REQ: begin
        if (!tx_busy) state_nx = S_TX_WAIT;
        if (byte_ev)  err_now  = 1'b1;
      end
      S_TX_WAIT: begin
        if (seen_busy && !tx_busy) state_nx = S_IDLE;
        else if (!seen_busy && !tx_busy && to_hit) begin
          err_now  = 1'b1;
          state_nx = S_IDLE;
        end
        if (byte_ev) err_now = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    tx_start = (state == S_TX_REQ) && !tx_busy;
    strobe   = 16'h0000;
    if (state == S_EXEC && frm.op == OP_ST) strobe = 16'h0001 << frm.addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev   <= 1'b1;
      frm       <= '0;
      to_cnt    <= '0;
      seen_busy <= 1'b0;
      bank      <= '0;
      tx_data   <= 8'h00;
      err       <= 1'b0;
      err_count <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      rx_prev <= rx_done;
      // Counter restarts on every state change, so each wait state sees a fresh budget.
      if (state != state_nx) to_cnt <= '0;
      else                   to_cnt <= to_cnt + 1'b1;
      if (state != S_TX_WAIT) seen_busy <= 1'b0;
      else if (tx_busy)       seen_busy <= 1'b1;
      if (state == S_IDLE && byte_ev) begin
        frm.op   <= rx_data[7:4];
        frm.addr <= rx_data[3:0];
`ifdef UART_CMD_CHECKSUM_EN
        csum     <= rx_data;
`endif
      end
      if (state == S_WAIT_DATA && byte_ev) begin
        frm.data <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
        csum     <= csum ^ rx_data;
`endif
      end
      if (state == S_EXEC && addr_ok) begin
        if (frm.op == OP_WR) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (frm.addr == 4'(i)) bank[i] <= frm.data;
        end
        if (frm.op == OP_RD) tx_data <= rd_byte;
      end
      err <= err_now;
      if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule
